// File: rtl/cdma_pkg.sv
// Shared CDMA scheduler types and widths. The despreader also uses these.
package cdma_pkg;

  localparam int DEF_DATA_W   = 4;
  localparam int DEF_CODE_LEN = 4;
  localparam int CHIP_IDX_W   = $clog2(DEF_CODE_LEN);
  localparam int BIT_IDX_W    = $clog2(DEF_DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_LOAD,
    S_SEND,
    S_DONE
  } sched_state_t;

  // Counter width that stays at least 1 bit, even for a modulus of 1
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdma_chip_timer.sv
// Chip prescaler and chip index counter. Strobes on the first cycle of every chip and
// flags the final cycle of a bit.
module cdma_chip_timer
  import cdma_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter int CHIP_DIV = 50,
  parameter int CHIP_W   = $clog2(CODE_LEN)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clr,
  output logic              o_chip_stb,
  output logic              o_bit_wrap,
  output logic [CHIP_W-1:0] o_chip_idx
);
  localparam int DIV_W = cnt_w(CHIP_DIV);

  logic [DIV_W-1:0]  r_div;
  logic [CHIP_W-1:0] r_chip;
  logic              w_div_last;
  logic              w_chip_last;

  assign w_div_last  = (r_div == DIV_W'(CHIP_DIV - 1));
  assign w_chip_last = (r_chip == CHIP_W'(CODE_LEN - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div  <= '0;
      r_chip <= '0;
    end else if (i_clr) begin
      r_div  <= '0;
      r_chip <= '0;
    end else if (i_en) begin
      r_div <= w_div_last ? '0 : r_div + 1'b1;
      if (w_div_last) r_chip <= w_chip_last ? '0 : r_chip + 1'b1;
    end
  end

  assign o_chip_stb = i_en & (r_div == '0);
  assign o_bit_wrap = i_en & w_div_last & w_chip_last;
  assign o_chip_idx = r_chip;

endmodule

// File: rtl/cdma_frame_scheduler.sv
// CDMA frame scheduler: gathers one word per user, then walks bits MSB-first, chip by chip.
// Define CDMA_PILOT_EN to prepend an all-ones pilot bit and expose pilot_flag.
module cdma_frame_scheduler
  import cdma_pkg::*;
#(
  parameter int NUM_USERS  = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CODE_LEN   = DEF_CODE_LEN,
  parameter int CHIP_DIV   = 50,
  parameter int GATHER_CYC = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [NUM_USERS-1:0]          usr_valid,
  input  logic [NUM_USERS*DATA_W-1:0]   usr_data,
  output logic [NUM_USERS-1:0]          usr_ready,
  output logic [NUM_USERS-1:0]          user_mask,
  output logic [NUM_USERS-1:0]          tx_bits,
  output logic                          chip_stb,
  output logic [$clog2(CODE_LEN)-1:0]   chip_idx,
  output logic [$clog2(DATA_W+1)-1:0]   bit_idx,
  output logic                          frame_start,
  output logic                          frame_done,
  output logic                          busy
`ifdef CDMA_PILOT_EN
  ,
  output logic                          pilot_flag
`endif
);
`ifdef CDMA_PILOT_EN
  localparam int PIL = 1;
`else
  localparam int PIL = 0;
`endif
  localparam int CHIP_W   = $clog2(CODE_LEN);
  localparam int BIT_W    = $clog2(DATA_W + 1);
  localparam int LAST_BIT = DATA_W - 1 + PIL;
  localparam int G_W      = cnt_w(GATHER_CYC);
  localparam int G_LAST   = (GATHER_CYC > 0) ? GATHER_CYC - 1 : 0;

  sched_state_t                          r_state, w_next;
  logic [G_W-1:0]                        r_gcnt;
  logic [NUM_USERS-1:0]                  r_mask;
  logic [NUM_USERS-1:0][DATA_W-1:0]      r_words;
  logic [BIT_W-1:0]                      r_bit;
  logic [BIT_W-1:0]                      w_dsel;
  logic [DATA_W-1:0]                     w_word;
  logic [NUM_USERS-1:0]                  w_tx;
  logic                                  w_send, w_chip_stb, w_bit_wrap;
  logic [CHIP_W-1:0]                     w_chip_idx;

  assign w_send = (r_state == S_SEND);

  cdma_chip_timer #(
    .CODE_LEN(CODE_LEN),
    .CHIP_DIV(CHIP_DIV),
    .CHIP_W  (CHIP_W)
  ) u_timer (
    .i_clk     (CLOCK_50),
    .i_rst     (reset),
    .i_en      (w_send),
    .i_clr     (!w_send),
    .o_chip_stb(w_chip_stb),
    .o_bit_wrap(w_bit_wrap),
    .o_chip_idx(w_chip_idx)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|usr_valid) w_next = (GATHER_CYC == 0) ? S_LOAD : S_GATHER;
      S_GATHER: if (r_gcnt == G_W'(G_LAST)) w_next = S_LOAD;
      S_LOAD:   w_next = (|usr_valid) ? S_SEND : S_IDLE;
      S_SEND:   if (w_bit_wrap && r_bit == BIT_W'(LAST_BIT)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_gcnt  <= '0;
      r_mask  <= '0;
      r_words <= '0;
      r_bit   <= '0;
    end else begin
      r_gcnt <= (r_state == S_GATHER) ? r_gcnt + 1'b1 : '0;
      if (r_state == S_LOAD) begin
        r_mask <= usr_valid;
        for (int i = 0; i < NUM_USERS; i++)
          if (usr_valid[i]) r_words[i] <= usr_data[i*DATA_W +: DATA_W];
      end
      if (!w_send)        r_bit <= '0;
      else if (w_bit_wrap) r_bit <= (r_bit == BIT_W'(LAST_BIT)) ? '0 : r_bit + 1'b1;
    end
  end

  // Bit position counts down from the MSB; the pilot period shifts data bits up by one
  always_comb begin
    w_tx   = '0;
    w_word = '0;
    w_dsel = BIT_W'(LAST_BIT) - r_bit;
    for (int i = 0; i < NUM_USERS; i++) begin
      w_word  = r_words[i] >> w_dsel;
      w_tx[i] = w_word[0] & r_mask[i];
    end
    if (PIL == 1 && r_bit == '0) w_tx = r_mask;
    if (!w_send) w_tx = '0;
  end

  assign usr_ready   = (r_state == S_LOAD) ? usr_valid : '0;
  assign user_mask   = w_send ? r_mask : '0;
  assign tx_bits     = w_tx;
  assign chip_stb    = w_chip_stb;
  assign chip_idx    = w_chip_idx;
  assign bit_idx     = r_bit;
  assign frame_start = w_chip_stb & (r_bit == '0) & (w_chip_idx == '0);
  assign frame_done  = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
`ifdef CDMA_PILOT_EN
  assign pilot_flag  = w_send & (r_bit == '0);
`endif

endmodule

// File: tb/tb_cdma_frame_scheduler.sv
// Directed bench for cdma_frame_scheduler (2 users, 4-bit words, 4 chips, CHIP_DIV=2, GATHER_CYC=3).
module tb_cdma_frame_scheduler;
`ifdef CDMA_PILOT_EN
  localparam int PIL = 1;
`else
  localparam int PIL = 0;
`endif
  localparam int NB       = 4 + PIL;
  localparam int SEND_CYC = NB * 4 * 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [1:0] usr_valid = '0;
  logic [7:0] usr_data  = '0;
  logic [1:0] usr_ready, user_mask, tx_bits;
  logic       chip_stb, frame_start, frame_done, busy;
  logic [1:0] chip_idx;
  logic [2:0] bit_idx;
`ifdef CDMA_PILOT_EN
  logic       pilot_flag;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cdma_frame_scheduler #(
    .NUM_USERS(2), .DATA_W(4), .CODE_LEN(4), .CHIP_DIV(2), .GATHER_CYC(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .usr_valid(usr_valid), .usr_data(usr_data),
    .usr_ready(usr_ready), .user_mask(user_mask), .tx_bits(tx_bits), .chip_stb(chip_stb),
    .chip_idx(chip_idx), .bit_idx(bit_idx), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy)
`ifdef CDMA_PILOT_EN
    , .pilot_flag(pilot_flag)
`endif
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  // Steps until usr_ready fires (the LOAD cycle), bounded
  task automatic wait_load(input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (usr_ready == 2'b00 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_load_lat"}, n, exp_cyc);
  endtask

  // Called in the LOAD cycle; checks the whole SEND phase, DONE and the return to IDLE
  task automatic run_frame(input string tag, input logic [1:0] m,
                           input logic [1:0] t0, input logic [1:0] t1,
                           input logic [1:0] t2, input logic [1:0] t3,
                           input logic [1:0] nxt_v, input logic [7:0] nxt_d);
    logic [3:0][1:0] tt;
    int b;
    tt = {t3, t2, t1, t0};
    chk({tag, "_ready"}, usr_ready, m);
    for (int k = 0; k < SEND_CYC; k++) begin
      step();
      if (k == 0) begin
        usr_valid = nxt_v;
        usr_data  = nxt_d;
      end
      b = k / 8;
      chk({tag, "_stb"}, chip_stb, (k % 2) == 0);
      chk({tag, "_fstart"}, frame_start, k == 0);
      chk({tag, "_ready_send"}, usr_ready, 2'b00);
      chk({tag, "_fdone_send"}, frame_done, 1'b0);
      if (k % 2 == 0) chk({tag, "_chip_idx"}, chip_idx, (k / 2) % 4);
      if (k % 8 == 0) begin
        chk({tag, "_bit_idx"}, bit_idx, b);
        chk({tag, "_mask"}, user_mask, m);
        chk({tag, "_tx"}, tx_bits, (b < PIL) ? m : tt[b - PIL]);
`ifdef CDMA_PILOT_EN
        chk({tag, "_pilot"}, pilot_flag, b == 0);
`endif
      end
    end
    step();
    chk({tag, "_fdone"}, frame_done, 1'b1);
    chk({tag, "_mask_done"}, user_mask, 2'b00);
    chk({tag, "_tx_done"}, tx_bits, 2'b00);
    chk({tag, "_busy_done"}, busy, 1'b1);
    step();
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_fdone_idle"}, frame_done, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {usr_ready, user_mask, tx_bits, chip_stb, chip_idx, bit_idx,
                     frame_start, frame_done}, 0);
    step(); step();
    reset = 1'b0;

    // 1: both users
    usr_valid = 2'b11; usr_data = {4'b0110, 4'b1010};
    wait_load("t1", 4);
    run_frame("t1", 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 8'h00);

    // 2: only user 1
    usr_valid = 2'b10; usr_data = {4'b1111, 4'b0000};
    wait_load("t2", 4);
    run_frame("t2", 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 8'h00);

    // 3: late joiner inside the window, then one arriving during SEND
    usr_valid = 2'b01; usr_data = {4'b0101, 4'b0011};
    step(); step();
    usr_valid = 2'b11;
    wait_load("t3a", 2);
    run_frame("t3a", 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10, {4'b1001, 4'b0000});
    wait_load("t3b", 4);
    run_frame("t3b", 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 8'h00);

    // 4: valid vanishes before LOAD
    usr_valid = 2'b01; usr_data = 8'h0F;
    step();
    usr_valid = 2'b00;
    chk("t4_busy_gather", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_ready", usr_ready, 2'b00);
      chk("t4_fstart", frame_start, 1'b0);
    end
    chk("t4_idle", busy, 1'b0);
    step();
    chk("t4_stay_idle", busy, 1'b0);

    // 5: reset at chip 7 of SEND
    usr_valid = 2'b11; usr_data = {4'b0110, 4'b1010};
    wait_load("t5", 4);
    chk("t5_ready", usr_ready, 2'b11);
    for (int k = 0; k <= 14; k++) begin
      step();
      if (k == 0) usr_valid = 2'b00;
    end
    chk("t5_stb7", chip_stb, 1'b1);
    chk("t5_chip7", chip_idx, 2'd3);
    chk("t5_bit7", bit_idx, 3'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_mask_tx", {user_mask, tx_bits}, 0);
    chk("t5_rst_chip", {chip_stb, chip_idx, bit_idx}, 0);
    chk("t5_rst_flags", {frame_start, frame_done, usr_ready}, 0);
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("t5_no_fdone", frame_done, 1'b0);
      chk("t5_idle", busy, 1'b0);
    end

    // 6: u0 only (pilot period checked when built with the pilot option)
    usr_valid = 2'b01; usr_data = {4'b0000, 4'b1010};
    wait_load("t6", 4);
    run_frame("t6", 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
